// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, valid/ready on both sides.
// State byte 0 sits in bits [127:120], column-major; round key k is expanded_key[128*k +: 128].
module aes_decrypt_iter #(
   parameter int unsigned KEY_LATCH = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [127:0]    cipher_text,
   input  logic [0:1407]   expanded_key,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [127:0]    plain_text
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // FIPS-197 inverse S-box; entry n occupies bits [8n +: 8] of this ascending vector.
   localparam logic [0:2047] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // k is the multiplier constant as a bit mask over {x8, x4, x2, x1}.
   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xt(b);
      x4 = xt(x2);
      x8 = xt(x4);
      return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned i = 0; i < 16; i++)
         o[127 - 8*i -: 8] = INV_SBOX[{s[127 - 8*i -: 8], 3'b000} +: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
         o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
         o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
         o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
      end
      return o;
   endfunction

   logic [1:0]    fsm_q, fsm_d;
   logic [127:0]  state_q, state_d;
   logic [3:0]    rnd_q, rnd_d;
   logic [0:1407] key_src;
   logic [127:0]  rk;
   logic [127:0]  round_core;
   logic          accept;

   assign accept = in_valid && (fsm_q == S_IDLE);

   generate
      if (KEY_LATCH != 0) begin : g_key_latch
         logic [0:1407] key_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      key_q <= '0;
            else if (accept) key_q <= expanded_key;
         end
         assign key_src = key_q;
      end else begin : g_key_pass
         assign key_src = expanded_key;
      end
   endgenerate

   assign rk         = key_src[{rnd_q, 7'd0} +: 128];
   assign round_core = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk;

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rnd_d   = rnd_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid) begin
               // Key 10 comes straight from the port: the latched copy is not loaded yet.
               state_d = cipher_text ^ expanded_key[1280 +: 128];
               rnd_d   = 4'd9;
               fsm_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (rnd_q != 4'd0) begin
               state_d = inv_mix_columns(round_core);
               rnd_d   = rnd_q - 4'd1;
            end else begin
               state_d = round_core;
               fsm_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) fsm_d = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= S_IDLE;
         state_q <= '0;
         rnd_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rnd_q   <= rnd_d;
      end
   end

   assign in_ready   = (fsm_q == S_IDLE);
   assign out_valid  = (fsm_q == S_DONE);
   assign plain_text = state_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors, handshake corner cases, and random
// round trips through a forward-cipher reference model.
module tb_aes_decrypt_iter;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [127:0]    cipher_text;
   logic [0:1407]   expanded_key;
   logic            out_valid;
   logic            out_ready;
   logic [127:0]    plain_text;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   aes_decrypt_iter #(.KEY_LATCH(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .cipher_text  (cipher_text),
      .expanded_key (expanded_key),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .plain_text   (plain_text)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Forward cipher reference; the S-box is derived from GF inverse + affine map.
   logic [7:0] sb [256];

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   task automatic init_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [0:1407] key_expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [0:1407] ek;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) ek[32*i +: 32] = w[i];
      return ek;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [0:1407] ek);
      logic [127:0] s, t;
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ ek[0 +: 128];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = sb[s[127 - 8*i -: 8]];
         t = s;
         for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
               s[127 - 8*(4*c + rw) -: 8] = t[127 - 8*(4*((c + rw) % 4) + rw) -: 8];
         if (r < 10) begin
            t = s;
            for (int c = 0; c < 4; c++) begin
               a0 = t[127 - 32*c -: 8];
               a1 = t[119 - 32*c -: 8];
               a2 = t[111 - 32*c -: 8];
               a3 = t[103 - 32*c -: 8];
               s[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
               s[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
               s[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
               s[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
         end
         s = s ^ ek[128*r +: 128];
      end
      return s;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the accept edge.
   task automatic send(input logic [127:0] ct, input logic [0:1407] ek);
      int   n;
      logic acc;
      n = 0;
      in_valid     = 1'b1;
      cipher_text  = ct;
      expanded_key = ek;
      do begin
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) chk("accept_timeout", 128'(acc), 128'(1));
      in_valid    = 1'b0;
      cipher_text = 'x;
   endtask

   // lat counts the accept edge as clock 1.
   task automatic recv(output logic [127:0] pt, output int lat);
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      pt = plain_text;
   endtask

   typedef struct {
      string        name;
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t          vt [3];
   logic [127:0]  got;
   int            lat;
   logic [0:1407] ek;
   logic [127:0]  bp [4];
   logic [127:0]  bc [4];
   logic [0:1407] bek [4];

   initial begin
      vt[0] = '{"fips_c1",   128'h000102030405060708090a0b0c0d0e0f,
                             128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                             128'h00112233445566778899aabbccddeeff};
      vt[1] = '{"fips_appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                             128'h3925841d02dc09fbdc118597196a0b32,
                             128'h3243f6a8885a308d313198a2e0370734};
      vt[2] = '{"zero_key",  128'h0,
                             128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                             128'h0};

      rst_n        = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b1;
      cipher_text  = '0;
      expanded_key = '0;
      init_sbox();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_plain_text", plain_text, 128'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 128'(in_ready), 128'(1));

      // Directed vectors; the key input is scrambled after accept to exercise the key latch.
      for (int i = 0; i < 3; i++) begin
         ek = key_expand(vt[i].key);
         send(vt[i].ct, ek);
         expanded_key = ~ek;
         recv(got, lat);
         chk({vt[i].name, "_pt"}, got, vt[i].pt);
         chk({vt[i].name, "_latency"}, 128'(lat), 128'(11));
         @(posedge clk); #1;
         chk({vt[i].name, "_ovalid_drop"}, 128'(out_valid), 128'(0));
         chk({vt[i].name, "_iready_back"}, 128'(in_ready), 128'(1));
      end

      // Backpressure: DONE held for 5 clocks with out_ready low.
      out_ready = 1'b0;
      ek = key_expand(vt[0].key);
      send(vt[0].ct, ek);
      recv(got, lat);
      chk("bp_latency", 128'(lat), 128'(11));
      for (int k = 0; k < 5; k++) begin
         chk("bp_ovalid_hold", 128'(out_valid), 128'(1));
         chk("bp_iready_low", 128'(in_ready), 128'(0));
         chk("bp_pt_stable", plain_text, vt[0].pt);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      chk("bp_ovalid_at_hs", 128'(out_valid), 128'(1));
      chk("bp_iready_at_hs", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      chk("bp_ovalid_after", 128'(out_valid), 128'(0));
      chk("bp_iready_after", 128'(in_ready), 128'(1));

      // Reset while RUN holds rnd=5; the block must vanish.
      send(vt[0].ct, ek);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      chk("midrst_ovalid", 128'(out_valid), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_iready", 128'(in_ready), 128'(1));
      chk("midrst_pt_clear", plain_text, 128'h0);
      begin
         int bad;
         bad = 0;
         repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
         end
         chk("midrst_no_ovalid", 128'(bad), 128'(0));
      end
      send(vt[0].ct, ek);
      recv(got, lat);
      chk("midrst_next_pt", got, vt[0].pt);
      chk("midrst_next_latency", 128'(lat), 128'(11));
      @(posedge clk); #1;

      // Back-to-back: in_valid stays high across four blocks.
      for (int i = 0; i < 4; i++) begin
         bek[i] = key_expand({$urandom, $urandom, $urandom, $urandom});
         bp[i]  = {$urandom, $urandom, $urandom, $urandom};
         bc[i]  = encrypt(bp[i], bek[i]);
      end
      fork
         begin : b2b_drive
            int   n;
            logic acc;
            in_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
               cipher_text  = bc[i];
               expanded_key = bek[i];
               n = 0;
               do begin
                  acc = in_ready;
                  @(posedge clk); #1;
                  n++;
               end while (!acc && n < 40);
               if (!acc) chk("b2b_accept_timeout", 128'(acc), 128'(1));
            end
            in_valid = 1'b0;
         end
         begin : b2b_recv
            int n;
            int last;
            last = 0;
            for (int i = 0; i < 4; i++) begin
               n = 0;
               while (!out_valid && n < 40) begin
                  @(posedge clk); #1;
                  n++;
               end
               chk("b2b_pt", plain_text, bp[i]);
               if (i > 0) chk("b2b_spacing", 128'(cyc - last), 128'(12));
               last = cyc;
               @(posedge clk); #1;
            end
         end
      join

      // Random round trips through the forward reference.
      for (int i = 0; i < 1000; i++) begin
         logic [127:0] p, c;
         ek = key_expand({$urandom, $urandom, $urandom, $urandom});
         p  = {$urandom, $urandom, $urandom, $urandom};
         c  = encrypt(p, ek);
         send(c, ek);
         recv(got, lat);
         chk("roundtrip_pt", got, p);
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
